io_bus_arbiter: RTL
===================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default `NUM_CORES: number of I/O request sources (1..16).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  NUM_REQUESTERS  per-requester request pending.
REQ-005 SHALL have port req_packet  input  ioreq_packet_t[NUM_REQUESTERS]  per-requester request: is_store, thread_idx, address, value.
REQ-006 SHALL have port req_ack  output  NUM_REQUESTERS  one-hot, one-cycle request acceptance.
REQ-007 SHALL have port rsp_valid  output  1  response broadcast valid, one cycle.
REQ-008 SHALL have port rsp_packet  output  iorsp_packet_t  response: core, thread_idx, read_value.
REQ-009 SHALL have port io_bus  io_bus_interface.master  single shared non-cached peripheral bus.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESPONSE; exactly one transaction in flight.
REQ-011 IDLE: if any req_valid set, SHALL select one requester, assert its req_ack combinationally in that cycle, latch its packet and index, go to ACCESS; else stay IDLE with req_ack = 0.
REQ-012 Selection SHALL be round-robin: search starts at (last_grant + 1) mod NUM_REQUESTERS and wraps; last_grant updates only on acceptance.
REQ-013 Requester SHALL hold req_valid and req_packet stable until req_ack; arbiter SHALL sample the packet only in the ack cycle.
REQ-014 ACCESS (exactly one cycle): SHALL drive io_bus.address and io_bus.write_data from the latched packet and assert write_en if is_store, else read_en; never both.
REQ-015 Outside ACCESS, write_en and read_en SHALL be 0; address and write_data SHALL hold their last values.
REQ-016 RESPONSE (exactly one cycle): SHALL assert rsp_valid with core = latched index zero-extended to core_id_t, thread_idx = latched thread_idx, read_value = io_bus.read_data for loads and 32'h0 for stores; then go to IDLE.
REQ-017 Stores SHALL also produce a response so the issuing thread can resume.
REQ-018 Latency: ack cycle N, bus strobe N+1, rsp_valid N+2; next ack no earlier than N+3; peak throughput 1 transaction per 3 cycles.
REQ-019 req_valid arriving in ACCESS or RESPONSE SHALL wait; no ack outside IDLE.
REQ-020 Simultaneous requests: exactly one ack per IDLE acceptance; others remain pending, none lost.
REQ-021 NUM_REQUESTERS = 1: SHALL grant requester 0 without round-robin state.

Reset
REQ-022 On reset assertion, FSM SHALL go immediately to IDLE; last_grant SHALL = NUM_REQUESTERS-1, so requester 0 has first priority.
REQ-023 During reset: req_ack = 0, rsp_valid = 0, write_en = 0, read_en = 0, address = 0, write_data = 0, rsp_packet = 0.
REQ-024 Reset mid-transaction SHALL abort it silently; no response for the aborted request.

Configuration
REQ-025 With macro IO_ARB_PERF_EN defined, SHALL add output perf_events[2:0]: bit0 = read strobe, bit1 = write strobe, bit2 = cycle with req_valid != 0 and no ack; each a one-cycle pulse, reset to 0.
REQ-026 Without IO_ARB_PERF_EN, perf_events port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Single load: req_valid[0]=1, address 32'hFFFF0004, thread 2; read_data 32'h1234ABCD -> ack[0] cycle N, read_en=1 cycle N+1, rsp_valid N+2 with core 0, thread 2, read_value 32'h1234ABCD.
REQ-028 Single store: req_valid[1]=1, is_store, address 32'hFFFF0010, value 32'hDEADBEEF -> write_en=1 with those values at N+1, read_en=0, rsp_valid N+2 with core 1, read_value 0.
REQ-029 Round-robin with 4 requesters all held valid from reset -> acks in order 0,1,2,3,0 spaced 3 cycles; no requester starved.
REQ-030 Reset asserted during ACCESS of a load -> strobes drop asynchronously, no rsp_valid; after release, next pending request acked from requester 0 priority.
REQ-031 Request raised during RESPONSE -> no ack until following IDLE cycle; write_en and read_en never simultaneously 1 across 1000 random transactions.
REQ-032 With IO_ARB_PERF_EN: 3 loads, 2 stores, 1 blocked cycle -> perf_events bit0 pulses 3, bit1 pulses 2, bit2 counts stalled-request cycles exactly.

Source files
------------

// File: rtl/io_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// io_bus_interface
// Purpose : single shared, non-cached peripheral bus. One master (the I/O
//           arbiter) issues at most one read or write strobe per cycle; the
//           peripheral side returns read_data for loads.
// Signals : write_en   - write strobe (master -> slave)
//           read_en    - read strobe (master -> slave)
//           address    - 32-bit peripheral address (master -> slave)
//           write_data - 32-bit store data (master -> slave)
//           read_data  - 32-bit load data (slave -> master)
// -----------------------------------------------------------------------------
interface io_bus_interface;
    logic        write_en;
    logic        read_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output write_en,
        output read_en,
        output address,
        output write_data,
        input  read_data
    );

    modport slave (
        input  write_en,
        input  read_en,
        input  address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter
// Purpose : funnels I/O requests from NUM_REQUESTERS cores onto one shared
//           peripheral bus. Exactly one transaction is in flight; each one
//           takes three cycles (accept, bus strobe, response broadcast).
//           Requesters are served round-robin.
// Ports   : clk          - clock, rising edge
//           reset        - asynchronous, active-high reset
//           req_valid    - per-requester request pending
//           req_packet   - per-requester request (is_store, thread_idx,
//                          address, value)
//           req_ack      - one-hot, one-cycle acceptance (combinational)
//           rsp_valid    - one-cycle response broadcast valid
//           rsp_packet   - response (core, thread_idx, read_value)
//           io_bus       - shared peripheral bus, master side
//           perf_events  - [0] read strobe, [1] write strobe, [2] request
//                          pending but not accepted (only with macro
//                          IO_ARB_PERF_EN defined)
//           dbg_state_o  - current FSM state, for observation
// Options : `define IO_ARB_PERF_EN to add the perf_events output.
// -----------------------------------------------------------------------------
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package io_arb_pkg;
    typedef logic [3:0] core_id_t;
    typedef logic [3:0] local_thread_idx_t;

    typedef struct packed {
        logic              is_store;
        local_thread_idx_t thread_idx;
        logic [31:0]       address;
        logic [31:0]       value;
    } ioreq_packet_t;

    typedef struct packed {
        core_id_t          core;
        local_thread_idx_t thread_idx;
        logic [31:0]       read_value;
    } iorsp_packet_t;
endpackage

module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int NUM_REQUESTERS = `NUM_CORES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] req_valid,
    input  ioreq_packet_t             req_packet [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] req_ack,
    output logic                      rsp_valid,
    output iorsp_packet_t             rsp_packet,
    io_bus_interface.master           io_bus,
`ifdef IO_ARB_PERF_EN
    output logic [2:0]                perf_events,
`endif
    output logic [1:0]                dbg_state_o
);

    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACCESS   = 2'd1;
    localparam logic [1:0] S_RESPONSE = 2'd2;

    // Handshake: a requester raises req_valid with a stable req_packet and
    // holds both until it sees req_ack high for one cycle. req_ack is only
    // ever raised in IDLE, for exactly one requester, and the packet is
    // captured on the clock edge that ends the ack cycle.

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] sel_idx;
    logic             any_req;
    logic             accept;

    logic              is_store_q;
    local_thread_idx_t thread_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;

    logic read_strobe;
    logic write_strobe;

    assign any_req = |req_valid;
    // reset gates the combinational ack so nothing is granted while held
    assign accept  = (state_q == S_IDLE) && any_req && !reset;

    // ------------------------------------------------------------------
    // Requester selection
    // ------------------------------------------------------------------
    generate
        if (NUM_REQUESTERS == 1) begin : g_single
            assign sel_idx = '0;
        end else begin : g_rr
            logic [IDX_W-1:0] last_grant_q;
            logic [IDX_W-1:0] cand_idx;
            logic             found;
            int               cand;

            // Last grant resets to the highest index so requester 0 is
            // searched first after reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    last_grant_q <= IDX_W'(NUM_REQUESTERS - 1);
                end else if (accept) begin
                    last_grant_q <= sel_idx;
                end
            end

            // Search starts one past the last grant and wraps; the first
            // pending requester found wins.
            always_comb begin
                sel_idx  = last_grant_q;
                found    = 1'b0;
                cand     = 0;
                cand_idx = '0;
                for (int i = 0; i < NUM_REQUESTERS; i++) begin
                    cand     = (int'(last_grant_q) + 1 + i) % NUM_REQUESTERS;
                    cand_idx = IDX_W'(cand);
                    if (!found && req_valid[cand_idx]) begin
                        sel_idx = cand_idx;
                        found   = 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            req_ack[i] = accept && (sel_idx == IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_ACCESS;
            S_ACCESS:   state_d = S_RESPONSE;
            S_RESPONSE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Address and write data are only loaded on acceptance, so they hold
    // their last values on the bus outside ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            thread_q   <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q <= req_packet[sel_idx].is_store;
                thread_q   <= req_packet[sel_idx].thread_idx;
                idx_q      <= sel_idx;
                addr_q     <= req_packet[sel_idx].address;
                wdata_q    <= req_packet[sel_idx].value;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus and response outputs
    // ------------------------------------------------------------------
    assign write_strobe = (state_q == S_ACCESS) && is_store_q;
    assign read_strobe  = (state_q == S_ACCESS) && !is_store_q;

    assign io_bus.write_en   = write_strobe;
    assign io_bus.read_en    = read_strobe;
    assign io_bus.address    = addr_q;
    assign io_bus.write_data = wdata_q;

    assign rsp_valid = (state_q == S_RESPONSE);

    // Stores respond too (read_value 0) so the issuing thread can resume.
    always_comb begin
        rsp_packet = '0;
        if (rsp_valid) begin
            rsp_packet.core       = core_id_t'(idx_q);
            rsp_packet.thread_idx = thread_q;
            rsp_packet.read_value = is_store_q ? 32'h0 : io_bus.read_data;
        end
    end

`ifdef IO_ARB_PERF_EN
    assign perf_events = {any_req && !accept && !reset, write_strobe, read_strobe};
`endif

    assign dbg_state_o = state_q;

endmodule
